// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated-window frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // 1 ms window at 50 MHz
  localparam int unsigned GATE_CYCLES_DEFAULT = 50000;
  // Reference clock for converting a count to Hz: hz = count * SYS_CLK_HZ / GATE_CYCLES
  localparam int unsigned SYS_CLK_HZ = 50_000_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input and flags its rising edges.
// The previous-value flop tracks sync_out every cycle; load masks the edge on the arming cycle.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic load,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q & ~load;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts rising edges of sig_in over GATE_CYCLES
// clk_50M cycles per start request and reports a saturating count.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             overflow
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [CNT_W-1:0]   work_q, work_d;
  logic               wovf_q, wovf_d;
  logic [CNT_W-1:0]   edge_count_q, edge_count_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load;
  logic               rise;
  logic               unused_sig_s;

  // Only edges are counted here; the synchronized level is not needed
  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_50M (clk_50M),
    .rst     (rst),
    .load    (load),
    .async_in(sig_in),
    .sync_out(unused_sig_s),
    .rise    (rise)
  );

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT:   if (gate_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values and registered-output decode
  always_comb begin
    load         = 1'b0;
    gate_d       = gate_q;
    work_d       = work_q;
    wovf_d       = wovf_q;
    edge_count_d = edge_count_q;
    overflow_d   = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          gate_d = GATE_W'(GATE_CYCLES - 1);
          work_d = '0;
          wovf_d = 1'b0;
        end
      end
      COUNT: begin
        if (gate_q != '0) gate_d = gate_q - GATE_W'(1);
        if (rise) begin
          if (work_q == {CNT_W{1'b1}}) wovf_d = 1'b1;
          else                         work_d = work_q + CNT_W'(1);
        end
        // Publish on the edge that enters DONE, including this cycle's edge
        if (gate_q == '0) begin
          edge_count_d = work_d;
          overflow_d   = wovf_d;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      gate_q       <= '0;
      work_q       <= '0;
      wovf_q       <= 1'b0;
      edge_count_q <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      gate_q       <= gate_d;
      work_q       <= work_d;
      wovf_q       <= wovf_d;
      edge_count_q <= edge_count_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign edge_count = edge_count_q;
  assign overflow   = overflow_q;

endmodule
